// File: rtl/word_serializer_pkg.sv
// Shared types and helpers for the word serializer.
package word_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // The counter never needs to hold W itself (it reloads to W-1), so $clog2(W) bits suffice.
  function automatic int ser_cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Word-in / bit-out handshake bundle; the serializer sits on the slave side.
interface word_serializer_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic [W-1:0] in_word;
  logic         in_ready;
  logic         bit_valid;
  logic         bit_out;
  logic         bit_last;
  logic         bit_ready;
  logic         busy;

  modport master (
    output in_valid, in_word, bit_ready,
    input  in_ready, bit_valid, bit_out, bit_last, busy
  );

  modport slave (
    input  in_valid, in_word, bit_ready,
    output in_ready, bit_valid, bit_out, bit_last, busy
  );
endinterface

// File: rtl/dffen.sv
// Enabled register group with synchronous active-high clear to zero.
module dffen #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial shifter: first bit valid one cycle after acceptance, one bit per cycle.
// bit_ready low freezes everything; a new word is taken when idle or on the last-bit handshake.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int W         = 32,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  word_serializer_if.slave     ser
);

  localparam int CW      = ser_cnt_width(W);
  localparam bit MSB_OUT = (MSB_FIRST != 0);

  ser_state_t    state_q;
  ser_state_t    state_d;
  logic [0:0]    state_raw_q;
  logic [W-1:0]  shreg_q;
  logic [W-1:0]  shreg_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          load_en;
  logic          shift_en;
  logic          last_bit;
  logic          reg_en;

  assign state_q = ser_state_t'(state_raw_q);
  assign reg_en  = load_en | shift_en;

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    load_en       = 1'b0;
    shift_en      = 1'b0;
    last_bit      = 1'b0;
    ser.in_ready  = 1'b0;
    ser.bit_valid = 1'b0;
    ser.bit_out   = 1'b0;
    ser.bit_last  = 1'b0;
    ser.busy      = 1'b0;

    unique case (state_q)
      IDLE: begin
        ser.in_ready = 1'b1;
        load_en      = ser.in_valid;
      end
      SHIFT: begin
        last_bit      = (cnt_q == '0);
        ser.bit_valid = 1'b1;
        ser.busy      = 1'b1;
        ser.bit_last  = last_bit;
        ser.bit_out   = MSB_OUT ? shreg_q[W-1] : shreg_q[0];
        shift_en      = ser.bit_ready;
        // Handing over on the last bit is what removes the bubble between words.
        ser.in_ready  = shift_en && last_bit;
        load_en       = ser.in_ready && ser.in_valid;
      end
    endcase

    if (load_en) begin
      state_d = SHIFT;
      shreg_d = ser.in_word;
      cnt_d   = CW'(W - 1);
    end else if (shift_en) begin
      shreg_d = MSB_OUT ? (shreg_q << 1) : (shreg_q >> 1);
      if (last_bit) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q - 1'b1;
      end
    end
  end

  dffen #(.W(1)) u_state_reg (
    .clk   (clk),
    .reset (reset),
    .en_i  (reg_en),
    .d_i   (state_d),
    .q_o   (state_raw_q)
  );

  dffen #(.W(W)) u_shreg_reg (
    .clk   (clk),
    .reset (reset),
    .en_i  (reg_en),
    .d_i   (shreg_d),
    .q_o   (shreg_q)
  );

  dffen #(.W(CW)) u_cnt_reg (
    .clk   (clk),
    .reset (reset),
    .en_i  (reg_en),
    .d_i   (cnt_d),
    .q_o   (cnt_q)
  );

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: three configurations (W=8 MSB-first, W=8 LSB-first, W=1)
// checked each cycle against a queue of expected serial bits.
module tb_word_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [3];
  logic        iv     [3];
  logic [63:0] iw     [3];
  logic        br     [3];
  logic        o_rdy  [3];
  logic        o_vld  [3];
  logic        o_bit  [3];
  logic        o_last [3];
  logic        o_busy [3];

  int vectors     = 0;
  int miscompares = 0;

  logic [1:0]  mq[$];
  logic [63:0] rx;

  word_serializer_if #(.W(8)) if_a ();
  word_serializer_if #(.W(8)) if_b ();
  word_serializer_if #(.W(1)) if_c ();

  assign if_a.in_valid  = iv[0];
  assign if_a.in_word   = iw[0][7:0];
  assign if_a.bit_ready = br[0];
  assign o_rdy[0]  = if_a.in_ready;
  assign o_vld[0]  = if_a.bit_valid;
  assign o_bit[0]  = if_a.bit_out;
  assign o_last[0] = if_a.bit_last;
  assign o_busy[0] = if_a.busy;

  assign if_b.in_valid  = iv[1];
  assign if_b.in_word   = iw[1][7:0];
  assign if_b.bit_ready = br[1];
  assign o_rdy[1]  = if_b.in_ready;
  assign o_vld[1]  = if_b.bit_valid;
  assign o_bit[1]  = if_b.bit_out;
  assign o_last[1] = if_b.bit_last;
  assign o_busy[1] = if_b.busy;

  assign if_c.in_valid  = iv[2];
  assign if_c.in_word   = iw[2][0:0];
  assign if_c.bit_ready = br[2];
  assign o_rdy[2]  = if_c.in_ready;
  assign o_vld[2]  = if_c.bit_valid;
  assign o_bit[2]  = if_c.bit_out;
  assign o_last[2] = if_c.bit_last;
  assign o_busy[2] = if_c.busy;

  word_serializer #(.W(8), .MSB_FIRST(1)) u_msb8 (.clk(clk), .reset(rst[0]), .ser(if_a));
  word_serializer #(.W(8), .MSB_FIRST(0)) u_lsb8 (.clk(clk), .reset(rst[1]), .ser(if_b));
  word_serializer #(.W(1), .MSB_FIRST(1)) u_w1   (.clk(clk), .reset(rst[2]), .ser(if_c));

  function automatic int wid(input int s);
    return (s == 2) ? 1 : 8;
  endfunction

  function automatic bit msb(input int s);
    return (s != 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reset with the given in_valid/bit_ready applied, so reset priority is exercised too.
  task automatic do_reset(input int s, input logic v, input logic r);
    rst[s] = 1'b1;
    iv[s]  = v;
    iw[s]  = 64'hFF;
    br[s]  = r;
    @(posedge clk);
    @(negedge clk);
    rst[s] = 1'b0;
    iv[s]  = 1'b0;
    br[s]  = 1'b0;
    mq.delete();
    rx = '0;
    #1;
    chk("rst_bit_valid", 64'(o_vld[s]), 64'd0);
    chk("rst_bit_last", 64'(o_last[s]), 64'd0);
    chk("rst_bit_out", 64'(o_bit[s]), 64'd0);
    chk("rst_busy", 64'(o_busy[s]), 64'd0);
    chk("rst_in_ready", 64'(o_rdy[s]), 64'd1);
  endtask

  // One clock cycle: drive inputs, check outputs against the expected bit queue, advance the model.
  task automatic step(input int s, input logic v, input logic [63:0] w, input logic r);
    logic        exp_vld;
    logic        exp_rdy;
    int          n;
    logic [63:0] mask;
    n    = wid(s);
    mask = (64'd1 << n) - 64'd1;
    iv[s] = v;
    iw[s] = w;
    br[s] = r;
    #1;
    exp_vld = (mq.size() != 0);
    exp_rdy = !exp_vld || (r && mq[0][1]);
    chk("bit_valid", 64'(o_vld[s]), 64'(exp_vld));
    chk("busy", 64'(o_busy[s]), 64'(exp_vld));
    chk("in_ready", 64'(o_rdy[s]), 64'(exp_rdy));
    if (exp_vld) begin
      chk("bit_out", 64'(o_bit[s]), 64'(mq[0][0]));
      chk("bit_last", 64'(o_last[s]), 64'(mq[0][1]));
    end
    if (exp_vld && r) begin
      if (msb(s)) rx = ((rx << 1) | 64'(o_bit[s])) & mask;
      else        rx = (rx >> 1) | (64'(o_bit[s]) << (n - 1));
      void'(mq.pop_front());
    end
    if (v && exp_rdy) begin
      for (int i = 0; i < n; i++) begin
        mq.push_back({(i == n - 1), (msb(s) ? w[n-1-i] : w[i])});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic random_run(input int s, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      step(s, 1'($urandom_range(0, 1)), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
    end
    repeat (wid(s) + 2) step(s, 1'b0, 64'd0, 1'b1);
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      rst[s] = 1'b1;
      iv[s]  = 1'b0;
      iw[s]  = '0;
      br[s]  = 1'b0;
    end
    rx = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset(0, 1'b0, 1'b0);
    do_reset(1, 1'b0, 1'b0);
    do_reset(2, 1'b0, 1'b0);

    // W=8 MSB-first: 0xA5 streamed at full rate, loopback must rebuild it
    step(0, 1'b1, 64'hA5, 1'b1);
    repeat (8) step(0, 1'b0, 64'd0, 1'b1);
    chk("msb_loopback_a5", rx, 64'hA5);
    step(0, 1'b0, 64'd0, 1'b1);

    // 0x3C with bit_ready low for 3 cycles after bit 2
    step(0, 1'b1, 64'h3C, 1'b1);
    repeat (2) step(0, 1'b0, 64'd0, 1'b1);
    repeat (3) step(0, 1'b0, 64'd0, 1'b0);
    repeat (6) step(0, 1'b0, 64'd0, 1'b1);
    chk("stall_loopback_3c", rx, 64'h3C);

    // 0xFF then 0x00 back to back with in_valid held high
    step(0, 1'b1, 64'hFF, 1'b1);
    repeat (8) step(0, 1'b1, 64'h00, 1'b1);
    repeat (8) step(0, 1'b0, 64'd0, 1'b1);
    chk("b2b_loopback_00", rx, 64'h00);
    step(0, 1'b0, 64'd0, 1'b1);

    // reset while bit 4 of 0x5A is on the wire, then 0x81 must come out clean
    step(0, 1'b1, 64'h5A, 1'b1);
    repeat (3) step(0, 1'b0, 64'd0, 1'b1);
    do_reset(0, 1'b1, 1'b1);
    step(0, 1'b1, 64'h81, 1'b1);
    repeat (8) step(0, 1'b0, 64'd0, 1'b1);
    chk("post_abort_loopback_81", rx, 64'h81);

    random_run(0, 400);

    // W=8 LSB-first: 0xA5 into an LSB-shifting receiver
    step(1, 1'b1, 64'hA5, 1'b1);
    repeat (8) step(1, 1'b0, 64'd0, 1'b1);
    chk("lsb_loopback_a5", rx, 64'hA5);
    random_run(1, 400);

    // W=1: words 1,0,1 streamed, every bit is a last bit
    step(2, 1'b1, 64'd1, 1'b1);
    step(2, 1'b1, 64'd0, 1'b1);
    step(2, 1'b1, 64'd1, 1'b1);
    step(2, 1'b0, 64'd0, 1'b1);
    random_run(2, 300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 SHALL have parameter W, default 32: word width in bits; legal range 1..64.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = bit W-1 sent first, 0 = bit 0 sent first.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: in_word is offered.
REQ-006 SHALL have port in_word, input, W: parallel word to serialize.
REQ-007 SHALL have port in_ready, output, 1: a word is accepted on a cycle where in_valid && in_ready.
REQ-008 SHALL have port bit_valid, output, 1: bit_out carries a valid serial bit.
REQ-009 SHALL have port bit_out, output, 1: current serial bit.
REQ-010 SHALL have port bit_last, output, 1: bit_out is the final bit of the current word.
REQ-011 SHALL have port bit_ready, input, 1: the sink takes a bit on a cycle where bit_valid && bit_ready.
REQ-012 SHALL have port busy, output, 1: high while the block is in state SHIFT.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (no word held) and SHIFT (word held, bits pending).
REQ-014 SHALL in IDLE drive in_ready=1, bit_valid=0 and bit_last=0, and transition IDLE->SHIFT on in_valid && in_ready, loading in_word into a W-bit shift register and the bit counter to W-1.
REQ-015 SHALL in SHIFT drive bit_valid=1, with bit_out = shreg[W-1] when MSB_FIRST=1 and shreg[0] when MSB_FIRST=0.
REQ-016 SHALL on each bit handshake shift the register one position toward the output end, fill with 0, and decrement the counter.
REQ-017 SHALL assert bit_last exactly when the counter equals 0 in SHIFT.
REQ-018 SHALL hold bit_out, bit_last and all internal state unchanged while bit_valid && !bit_ready (backpressure; no bit is skipped or duplicated).
REQ-019 SHALL drive in_ready = (state==IDLE) || (bit_valid && bit_ready && bit_last).
REQ-020 SHALL on the last-bit handshake either load a new word and stay in SHIFT (if in_valid), or go to IDLE; this gives zero-bubble back-to-back words.
REQ-021 SHALL have a latency of 1 cycle: the first bit of an accepted word is valid on the cycle after acceptance.
REQ-022 SHALL, with sustained bit_ready and in_valid, emit one bit per cycle with no idle cycles between words.
REQ-023 SHALL, when W=1, assert bit_last on every bit and accept a new word on every bit handshake.
REQ-024 SHALL, with MSB_FIRST=1, send bits such that a W-bit serial-in register shifting toward its MSB on each bit_valid && bit_ready holds in_word after the bit_last handshake.
REQ-025 SHALL use a counter width of max(1, $clog2(W)) bits; it never wraps, because a reload occurs at 0.
REQ-026 SHALL ignore in_word whenever in_ready=0.

Reset
REQ-027 SHALL on reset force state=IDLE, shift register=0, counter=0, bit_valid=0, bit_last=0, busy=0 and bit_out=0.
REQ-028 SHALL treat reset during SHIFT as an abort: the partial word is discarded and no further bits are emitted.
REQ-029 SHALL give reset priority over a simultaneous in_valid or bit handshake.
REQ-030 SHALL drive in_ready=1 on the first cycle after reset deasserts.

Structure
REQ-031 SHALL place the FSM state enum (IDLE, SHIFT) in the shared package as ser_state_t.
REQ-032 SHALL implement state and datapath registers with the existing dffen flop, one instance per register group, enable = load or shift.
REQ-033 SHALL be a single module apart from dffen; no further sub-module is required.

Verification
REQ-034 SHALL cover: W=8, MSB_FIRST=1, word 0xA5, bit_ready=1 -> bits 1,0,1,0,0,1,0,1 on cycles 1..8 after acceptance, bit_last on the 8th, then in_ready=1.
REQ-035 SHALL cover: W=8, MSB_FIRST=0, word 0xA5 -> bits 1,0,1,0,0,1,0,1 (LSB first); a loopback into a LSB-shifting receiver yields 0xA5.
REQ-036 SHALL cover: bit_ready low for 3 cycles after bit 2 of 0x3C -> bit_out holds its value for all 3 cycles; the full sequence 0,0,1,1,1,1,0,0 is still emitted with no loss.
REQ-037 SHALL cover: back-to-back words 0xFF then 0x00 with in_valid held high -> 16 consecutive valid bits, second word accepted on the first word's bit_last cycle, no bubble.
REQ-038 SHALL cover: reset asserted at bit 4 of 0x5A -> bit_valid=0 next cycle; a following word 0x81 serializes cleanly as 1,0,0,0,0,0,0,1.
REQ-039 SHALL cover: W=1, words 1,0,1 streamed -> bit_last=1 on every bit and in_ready=1 on every bit handshake.
